// File: rtl/regfile_xfer_ctrl.sv
// Bulk dump/load engine between the 32-entry register file and a valid/ready word stream.
// Latency: dump 3 cycles/word (read, wait, present), load 2 cycles/word (accept, write); done 1 cycle after last word.
// Backpressure: dump holds out_valid/out_data until out_ready; load lowers in_ready while writing; enable=0 freezes everything.
// Optional: define REGFILE_XFER_CHECKSUM_EN for a running XOR of all transferred words on checksum.
module regfile_xfer_ctrl #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic          mode,
    input  logic [4:0]    base_addr,
    input  logic [5:0]    count,
    output logic [4:0]    rf_rd_addr,
    output logic          rf_read,
    input  logic [DW-1:0] rf_rd_data,
    output logic [4:0]    rf_wr_addr,
    output logic          rf_write,
    output logic [DW-1:0] rf_wr_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_D_RD, S_D_WAIT, S_D_OUT, S_L_IN, S_L_WR, S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    cur_addr, cur_nxt, cur_inc;
    logic [5:0]    remaining, rem_nxt;
    logic [4:0]    rd_addr_q, rd_addr_nxt;
    logic          rd_q, rd_nxt;
    logic [4:0]    wr_addr_q, wr_addr_nxt;
    logic [DW-1:0] wr_data_q, wr_data_nxt;
    logic          wr_q, wr_nxt;
    logic [DW-1:0] out_data_q, out_data_nxt;
    logic          out_valid_q, out_valid_nxt;
    logic          in_ready_q, in_ready_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;

    // next register address, wrapping at the top of the register file
    assign cur_inc = (cur_addr == 5'(NREG - 1)) ? 5'd0 : cur_addr + 5'd1;

    // next-state and next-output decode; nothing moves while enable is low
    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur_addr;
        rem_nxt       = remaining;
        rd_addr_nxt   = rd_addr_q;
        rd_nxt        = rd_q;
        wr_addr_nxt   = wr_addr_q;
        wr_data_nxt   = wr_data_q;
        wr_nxt        = wr_q;
        out_data_nxt  = out_data_q;
        out_valid_nxt = out_valid_q;
        in_ready_nxt  = in_ready_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_nxt = base_addr;
                        rem_nxt = count;
                        if (count == 6'd0) begin
                            state_nxt = S_FIN;
                        end else if (mode) begin
                            state_nxt    = S_L_IN;
                            in_ready_nxt = 1'b1;
                        end else begin
                            state_nxt   = S_D_RD;
                            rd_nxt      = 1'b1;
                            rd_addr_nxt = base_addr;
                        end
                    end
                end
                S_D_RD: begin
                    // the read strobe was visible this cycle, data arrives next cycle
                    state_nxt = S_D_WAIT;
                    rd_nxt    = 1'b0;
                end
                S_D_WAIT: begin
                    out_data_nxt  = rf_rd_data;
                    out_valid_nxt = 1'b1;
                    state_nxt     = S_D_OUT;
                end
                S_D_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_nxt = 1'b0;
                        cur_nxt       = cur_inc;
                        rem_nxt       = remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state_nxt = S_FIN;
                        end else begin
                            state_nxt   = S_D_RD;
                            rd_nxt      = 1'b1;
                            rd_addr_nxt = cur_inc;
                        end
                    end
                end
                S_L_IN: begin
                    if (in_valid && in_ready_q) begin
                        wr_addr_nxt  = cur_addr;
                        wr_data_nxt  = in_data;
                        wr_nxt       = 1'b1;
                        in_ready_nxt = 1'b0;
                        state_nxt    = S_L_WR;
                    end
                end
                S_L_WR: begin
                    wr_nxt  = 1'b0;
                    cur_nxt = cur_inc;
                    rem_nxt = remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt    = S_L_IN;
                        in_ready_nxt = 1'b1;
                    end
                end
                S_FIN: begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
            busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
        end
    end

    // state and output registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            rd_addr_q   <= '0;
            rd_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_addr    <= cur_nxt;
            remaining   <= rem_nxt;
            rd_addr_q   <= rd_addr_nxt;
            rd_q        <= rd_nxt;
            wr_addr_q   <= wr_addr_nxt;
            wr_data_q   <= wr_data_nxt;
            wr_q        <= wr_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
            in_ready_q  <= in_ready_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // Strobes stay registered and are held through a freeze, but enable masks
    // them so the register file and stream source see nothing while frozen; a
    // held read strobe reappears (and is consumed) once enable returns.
    assign rf_read    = rd_q & enable;
    assign rf_write   = wr_q & enable;
    assign in_ready   = in_ready_q & enable;
    assign rf_rd_addr = rd_addr_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef REGFILE_XFER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    // running XOR of every word moved; restarts on each accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (enable) begin
            if (state == S_IDLE && start)
                csum_q <= '0;
            else if (state == S_D_OUT && out_valid_q && out_ready)
                csum_q <= csum_q ^ out_data_q;
            else if (state == S_L_IN && in_ready_q && in_valid)
                csum_q <= csum_q ^ in_data;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Bench for regfile_xfer_ctrl with a behavioural 32x32 register file.
// Dump beats are checked against a queue of expected words filled before each start.
// Build with REGFILE_XFER_CHECKSUM_EN to also check the accumulator values.
module tb_regfile_xfer_ctrl;

`ifdef REGFILE_XFER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic        start;
    logic        mode;
    logic [4:0]  base_addr;
    logic [5:0]  count;
    logic [4:0]  rf_rd_addr;
    logic        rf_read;
    logic [31:0] rf_rd_data;
    logic [4:0]  rf_wr_addr;
    logic        rf_write;
    logic [31:0] rf_wr_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    regfile_xfer_ctrl #(.NREG(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
        .base_addr(base_addr), .count(count),
        .rf_rd_addr(rf_rd_addr), .rf_read(rf_read), .rf_rd_data(rf_rd_data),
        .rf_wr_addr(rf_wr_addr), .rf_write(rf_write), .rf_wr_data(rf_wr_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model: registered read, write on strobe, bench preload port
    logic [31:0] mem [0:31];
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    always @(posedge clk) begin
        if (rf_read) rf_rd_data <= mem[rf_rd_addr];
        if (rf_write) mem[rf_wr_addr] <= rf_wr_data;
        if (pl_we) mem[pl_addr] <= pl_data;
    end

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int hs_cnt = 0;
    int overlap_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;

    // event counters and scoreboard on the dump stream
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (rf_read) rd_cnt++;
            if (rf_write) wr_cnt++;
            if (rf_read && rf_write) overlap_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat: got out_data=%h, scoreboard empty", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w)
                        $display("FAIL beat: got out_data=%h, want %h", out_data, exp_w);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic start_xfer(input logic m, input logic [4:0] b, input logic [5:0] c);
        start = 1'b1; mode = m; base_addr = b; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (done_cnt == d0) $display("FAIL %s: no done within %0d cycles", name, budget);
        else n_pass++;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input string name);
        int k;
        bit ok;
        in_valid = 1'b1; in_data = w;
        ok = 1'b0;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL %s: word %h not accepted within 30 cycles", name, w);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; count = '0;
        out_ready = 1'b0; in_data = '0; in_valid = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) tick();
        n_checks++;
        if ({rf_read, rf_write, out_valid, in_ready, busy, done} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, want 000000", {rf_read, rf_write, out_valid, in_ready, busy, done});
        else n_pass++;
        n_checks++;
        if ({rf_rd_addr, rf_wr_addr} !== 10'b0) $display("FAIL reset_addr: got %h, want 0", {rf_rd_addr, rf_wr_addr});
        else n_pass++;
        n_checks++;
        if ({out_data, rf_wr_data} !== 64'b0) $display("FAIL reset_data: got %h, want 0", {out_data, rf_wr_data});
        else n_pass++;
        n_checks++;
        if (checksum !== 32'h0) $display("FAIL reset_csum: got %h, want 0", checksum);
        else n_pass++;
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b, want 0", busy);
        else n_pass++;
    endtask

    task automatic test_dump_basic();
        int d0;
        int r0;
        logic [31:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) preload(5'(i), vals[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        d0 = done_cnt; r0 = rd_cnt;
        out_ready = 1'b1;
        start_xfer(1'b0, 5'd0, 6'd4);
        wait_done(60, "dump_basic");
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL dump_basic_beats: %0d beats missing, want 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL dump_basic_done: got %0d pulses, want 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (rd_cnt - r0 != 4) $display("FAIL dump_basic_reads: got %0d, want 4", rd_cnt - r0);
        else n_pass++;
        n_checks++;
        if (checksum !== (CSUM_EN ? 32'h44 : 32'h0))
            $display("FAIL dump_basic_csum: got %h, want %h", checksum, CSUM_EN ? 32'h44 : 32'h0);
        else n_pass++;
    endtask

    task automatic test_load_wrap();
        int w0;
        logic [31:0] vals [4];
        logic [4:0]  addrs [4];
        vals = '{32'hA, 32'hB, 32'hC, 32'hD};
        addrs = '{5'd30, 5'd31, 5'd0, 5'd1};
        w0 = wr_cnt;
        start_xfer(1'b1, 5'd30, 6'd4);
        for (int i = 0; i < 4; i++) send_word(vals[i], "load_wrap");
        wait_done(30, "load_wrap");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[addrs[i]] !== vals[i])
                $display("FAIL load_wrap_reg%0d: got %h, want %h", addrs[i], mem[addrs[i]], vals[i]);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt - w0 != 4) $display("FAIL load_wrap_writes: got %0d, want 4", wr_cnt - w0);
        else n_pass++;
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        out_ready = 1'b1;
        start_xfer(1'b0, 5'd30, 6'd4);
        wait_done(60, "dump_wrap");
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL dump_wrap_beats: %0d beats missing, want 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (checksum !== 32'h0) $display("FAIL dump_wrap_csum: got %h, want 0", checksum);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int r0;
        int bad;
        bit seen;
        preload(5'd5, 32'h55);
        preload(5'd6, 32'h66);
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        out_ready = 1'b0;
        r0 = rd_cnt;
        start_xfer(1'b0, 5'd5, 6'd2);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) $display("FAIL bp_valid: out_valid never rose, want 1");
        else n_pass++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 32'h55) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (rd_cnt - r0 != 1) $display("FAIL bp_reads_stalled: got %0d reads, want 1", rd_cnt - r0);
        else n_pass++;
        tick();
        out_ready = 1'b1;
        wait_done(40, "bp");
        n_checks++;
        if (rd_cnt - r0 != 2) $display("FAIL bp_reads_total: got %0d, want 2", rd_cnt - r0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_beats: %0d beats missing, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_count_zero();
        int d0, r0, w0, h0;
        int busy_seen;
        d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; h0 = hs_cnt;
        busy_seen = 0;
        start_xfer(1'b0, 5'd3, 6'd0);
        @(negedge clk);
        if (busy) busy_seen++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL cnt0_done_early: got %b, want 0", done);
        else n_pass++;
        @(negedge clk);
        if (busy) busy_seen++;
        n_checks++;
        if (done !== 1'b1) $display("FAIL cnt0_done: got %b, want 1", done);
        else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if (busy || out_valid) busy_seen++;
        end
        tick();
        n_checks++;
        if (busy_seen != 0) $display("FAIL cnt0_busy: got %0d busy cycles, want 0", busy_seen);
        else n_pass++;
        n_checks++;
        if ((rd_cnt - r0) + (wr_cnt - w0) + (hs_cnt - h0) != 0)
            $display("FAIL cnt0_activity: got %0d strobes/beats, want 0", (rd_cnt - r0) + (wr_cnt - w0) + (hs_cnt - h0));
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL cnt0_pulses: got %0d, want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_enable_load();
        int w0;
        int bad;
        logic [31:0] vals [3];
        vals = '{32'h100, 32'h200, 32'h400};
        w0 = wr_cnt;
        start_xfer(1'b1, 5'd10, 6'd3);
        send_word(vals[0], "en_load");
        enable = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rf_write !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL en_frozen: %0d cycles with strobes, want 0", bad);
        else n_pass++;
        n_checks++;
        if (wr_cnt - w0 != 0) $display("FAIL en_no_write: got %0d writes, want 0", wr_cnt - w0);
        else n_pass++;
        tick();
        enable = 1'b1;
        send_word(vals[1], "en_load");
        send_word(vals[2], "en_load");
        wait_done(30, "en_load");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem[10 + i] !== vals[i]) $display("FAIL en_reg%0d: got %h, want %h", 10 + i, mem[10 + i], vals[i]);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt - w0 != 3) $display("FAIL en_writes: got %0d, want 3", wr_cnt - w0);
        else n_pass++;
        n_checks++;
        if (checksum !== (CSUM_EN ? 32'h700 : 32'h0))
            $display("FAIL en_csum: got %h, want %h", checksum, CSUM_EN ? 32'h700 : 32'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        bit hit;
        for (int i = 0; i < 8; i++) preload(5'(i), 32'h80 + i);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h80 + i);
        out_ready = 1'b1;
        d0 = done_cnt;
        start_xfer(1'b0, 5'd0, 6'd8);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid && hs_cnt >= 2) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) $display("FAIL rst_mid_reach: third beat not seen, want it");
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rf_read, rf_write, out_valid, in_ready, busy, done} !== 6'b0 || out_data !== 32'h0 || checksum !== 32'h0)
            $display("FAIL rst_mid_outputs: ctrl=%b data=%h csum=%h, want all 0",
                     {rf_read, rf_write, out_valid, in_ready, busy, done}, out_data, checksum);
        else n_pass++;
        exp_q.delete();
        repeat (4) tick();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (done_cnt != d0) $display("FAIL rst_mid_done: got %0d pulses, want 0", done_cnt - d0);
        else n_pass++;
        exp_q.push_back(32'h82);
        exp_q.push_back(32'h83);
        start_xfer(1'b0, 5'd2, 6'd2);
        wait_done(40, "rst_mid_after");
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rst_mid_after_beats: %0d beats missing, want 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (checksum !== (CSUM_EN ? 32'h1 : 32'h0))
            $display("FAIL rst_mid_csum: got %h, want %h", checksum, CSUM_EN ? 32'h1 : 32'h0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dump_basic();
        test_load_wrap();
        test_backpressure();
        test_count_zero();
        test_enable_load();
        test_reset_mid();
        n_checks++;
        if (overlap_cnt != 0) $display("FAIL rd_wr_overlap: got %0d cycles, want 0", overlap_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_xfer_ctrl.md
Name: regfile_xfer_ctrl

Overview:
- Bulk-transfer initiator for the 32x32 register file. Drives the register file's read/write address, strobe and data ports.
- Dump mode: reads a block of registers and streams them out over valid/ready.
- Load mode: accepts a valid/ready stream and writes it into consecutive registers.
- Sits between the register file and the debug/context-save path. Used for state save/restore and bench preload.

Parameters:
- NREG, 32, number of registers addressed; addresses wrap modulo NREG.
- DW, 32, data width of register and stream words.

Ports:
- clk  in  1  single clock; all state changes on posedge clk
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = FSM advances; 0 = FSM frozen, rf_read/rf_write forced 0
- start  in  1  one-cycle request; sampled only in IDLE with enable=1
- mode  in  1  0 = dump (read regs to stream), 1 = load (stream to regs)
- base_addr  in  5  first register address
- count  in  6  number of words, 0..32
- rf_rd_addr  out  5  register file read address
- rf_read  out  1  register file read strobe
- rf_rd_data  in  DW  register file read data, valid one clk after rf_read
- rf_wr_addr  out  5  register file write address
- rf_write  out  1  register file write strobe
- rf_wr_data  out  DW  register file write data
- out_data  out  DW  dump stream data
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- in_data  in  DW  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the transfer completes
- checksum  out  DW  see Optional Feature

Behaviour:
- Clocking and reset: one clock clk; reset is asynchronous and active-low. While reset=0, every output is 0 and the FSM is in IDLE.
- All outputs are registered.
- Start capture: in IDLE, start=1 with enable=1 latches mode, base_addr and count into internal registers. The start input is ignored in all other states.
- count=0: go directly to FIN. done pulses 2 cycles after start. No rf strobes and no stream beats are issued.
- FSM states: IDLE, D_RD, D_WAIT, D_OUT, L_IN, L_WR, FIN.
- D_RD: drive rf_rd_addr=cur_addr and rf_read=1 for exactly one cycle, then go to D_WAIT.
- D_WAIT: capture rf_rd_data into out_data, set out_valid=1, go to D_OUT.
- D_OUT: hold out_data and out_valid until out_valid & out_ready. On the handshake:
  - clear out_valid;
  - cur_addr = cur_addr+1 mod 32;
  - remaining = remaining-1;
  - go to FIN if remaining was 1, else D_RD.
- Dump throughput: minimum 3 cycles per word.
- L_IN: in_ready=1. On in_valid & in_ready:
  - register rf_wr_addr=cur_addr and rf_wr_data=in_data;
  - set rf_write=1;
  - drop in_ready;
  - go to L_WR.
- L_WR: rf_write stays high for exactly one cycle. Then advance cur_addr and remaining, and go to FIN or L_IN.
- Load throughput: minimum 2 cycles per word.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- busy is 1 in every non-IDLE state except FIN.
- Address wrap: base_addr=30 with count=4 touches registers 30, 31, 0, 1.
- enable=0 mid-transfer:
  - state, counters and out_valid/out_data are held;
  - rf_read, rf_write and in_ready are forced 0;
  - a pending D_RD issues its read once enable returns.
- Reset mid-transfer: aborts immediately. No done pulse. Register file contents already written are retained.
- rf_read and rf_write are never high in the same cycle.

Optional Feature:
- Macro: REGFILE_XFER_CHECKSUM_EN.
- When defined: checksum is a running XOR of every word transferred (dump beats on handshake, load words on accept). It clears to 0 on an accepted start and on reset, and holds its value after done.
- When undefined: checksum is tied to 0 and no accumulator logic exists.

Test Plan:
- Preload regs 0..3 with 0x11, 0x22, 0x33, 0x44; dump base=0, count=4, out_ready=1 -> out beats 0x11, 0x22, 0x33, 0x44 in order; done pulses once; with macro, checksum=0x44.
- Load base=30, count=4, stream 0xA, 0xB, 0xC, 0xD -> writes reg30=0xA, reg31=0xB, reg0=0xC, reg1=0xD; then dump base=30, count=4 -> same sequence.
- Dump count=2 with out_ready low for 5 cycles on the first beat -> out_data stable and out_valid held; no second rf_read until the first handshake.
- count=0 start -> no rf_read/rf_write/out_valid; done pulses 2 cycles after start; busy never set.
- Load of 3 words with enable dropped for 4 cycles after word 1 -> no rf_write or in_ready while enable=0; final registers hold all 3 words.
- Assert reset low during the third beat of an 8-word dump -> all outputs 0 immediately; no done; a subsequent start behaves normally.
